// File: rtl/tinyalu_ops_pkg.sv
// Shared TinyALU definitions: opcode and state encodings, multiplier latency,
// and the combinational evaluation of the single-cycle operations.
package tinyalu_ops_pkg;

    // Opcode encoding as seen on the op pins; 101-111 are reserved.
    typedef enum logic [2:0] {
        NO_OP    = 3'b000,
        ADD_OP   = 3'b001,
        AND_OP   = 3'b010,
        XOR_OP   = 3'b011,
        MUL_OP   = 3'b100,
        RSVD5_OP = 3'b101,
        RSVD6_OP = 3'b110,
        RSVD7_OP = 3'b111
    } operation_t;

    // Responder control states.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY_MUL = 2'b01,
        WAIT_LOW = 2'b10
    } state_t;

    // Number of pipeline stages in the multiplier (launch edge to out_valid edge).
    localparam int MUL_LATENCY = 3;

    // True for the opcodes that complete with illegal_op set.
    function automatic logic is_reserved(input operation_t op);
        is_reserved = (op == RSVD5_OP) || (op == RSVD6_OP) || (op == RSVD7_OP);
    endfunction

    // Result of every operation that completes on its launch edge.
    // The add keeps its carry in bit 8; reserved opcodes produce zero.
    function automatic logic [15:0] alu_single(input operation_t op,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            ADD_OP:  alu_single = {7'b0, sum};
            AND_OP:  alu_single = {8'b0, a & b};
            XOR_OP:  alu_single = {8'b0, a ^ b};
            default: alu_single = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_core_if.sv
// Start/done operation bus between an ALU initiator and the TinyALU responder.
interface tinyalu_core_if;
    import tinyalu_ops_pkg::*;

    logic        start;
    operation_t  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
    logic        busy;
    logic        illegal_op;

    // Initiator side: issues requests and observes completion.
    modport master (
        output start, op, A, B,
        input  done, result, busy, illegal_op
    );

    // Responder side: the core.
    modport slave (
        input  start, op, A, B,
        output done, result, busy, illegal_op
    );
endinterface

// File: rtl/tinyalu_mult3.sv
// Three-stage pipelined 8x8 unsigned multiplier with a matching valid shift
// register. Stage 1 captures operands, stage 2 forms two nibble partial
// products, stage 3 sums them into the 16-bit product.
module tinyalu_mult3
    import tinyalu_ops_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] product
);

    logic [7:0]             a_s1_reg;
    logic [7:0]             b_s1_reg;
    logic [11:0]            pp_lo_s2_reg;
    logic [11:0]            pp_hi_s2_reg;
    logic [15:0]            prod_s3_reg;
    logic [MUL_LATENCY-1:0] valid_reg;

    // Stage 1: hold the operands sampled on the launch edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1_reg <= 8'h00;
            b_s1_reg <= 8'h00;
        end else if (in_valid) begin
            a_s1_reg <= a;
            b_s1_reg <= b;
        end
    end

    // Stage 2: multiply by the low and high nibble of b separately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp_lo_s2_reg <= 12'h000;
            pp_hi_s2_reg <= 12'h000;
        end else begin
            pp_lo_s2_reg <= 12'(a_s1_reg) * 12'(b_s1_reg[3:0]);
            pp_hi_s2_reg <= 12'(a_s1_reg) * 12'(b_s1_reg[7:4]);
        end
    end

    // Stage 3: recombine the partial products (high one shifted by a nibble).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_s3_reg <= 16'h0000;
        end else begin
            prod_s3_reg <= {4'b0, pp_lo_s2_reg} + {pp_hi_s2_reg, 4'b0};
        end
    end

    // Valid token travels alongside the data, one flop per stage.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_LATENCY; gi++) begin : g_valid
            if (gi == 0) begin : g_first
                // First stage takes the launch strobe.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) valid_reg[gi] <= 1'b0;
                    else          valid_reg[gi] <= in_valid;
                end
            end else begin : g_next
                // Later stages follow the previous stage.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) valid_reg[gi] <= 1'b0;
                    else          valid_reg[gi] <= valid_reg[gi-1];
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[MUL_LATENCY-1];
    assign product   = prod_s3_reg;

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU responder: accepts one operation per start handshake, completes
// add/and/xor/reserved on the launch edge and mul three edges later, then
// pulses done with a held 16-bit result. A held start never relaunches; the
// initiator must be seen low once before the next request is accepted.
module tinyalu_core
    import tinyalu_ops_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    tinyalu_core_if.slave bus
);

    state_t      state_reg;
    state_t      state_next;
    logic        done_reg;
    logic        done_next;
    logic        illegal_reg;
    logic        illegal_next;
    logic [15:0] result_reg;
    logic [15:0] result_next;

    logic        launch;
    logic        launch_mul;
    logic        launch_single;
    logic        mul_valid;
    logic        mul_complete;
    logic [15:0] mul_product;

    // Launch qualification: only from IDLE, and a no_op request is ignored.
    assign launch        = (state_reg == IDLE) && bus.start && (bus.op != NO_OP);
    assign launch_mul    = launch && (bus.op == MUL_OP);
    assign launch_single = launch && (bus.op != MUL_OP);

    // The multiplier pipeline captures operands on the launch edge itself.
    tinyalu_mult3 u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (launch_mul),
        .a         (bus.A),
        .b         (bus.B),
        .out_valid (mul_valid),
        .product   (mul_product)
    );

    // Only a product belonging to the operation in flight counts as completion.
    assign mul_complete = (state_reg == BUSY_MUL) && mul_valid;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic: completion goes to WAIT_LOW while start is still held,
    // otherwise straight back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (launch_mul)         state_next = BUSY_MUL;
                else if (launch_single) state_next = WAIT_LOW;
            end
            BUSY_MUL: begin
                if (mul_valid) state_next = bus.start ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!bus.start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Completion outputs: done/illegal are one-cycle pulses, result is held.
    always_comb begin
        done_next    = launch_single || mul_complete;
        illegal_next = launch_single && is_reserved(bus.op);
        result_next  = result_reg;
        if (launch_single) begin
            result_next = alu_single(bus.op, bus.A, bus.B);
        end else if (mul_complete) begin
            result_next = mul_product;
        end
    end

    // Output registers; reset mid-operation clears the result and drops the op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            result_reg  <= 16'h0000;
        end else begin
            done_reg    <= done_next;
            illegal_reg <= illegal_next;
            result_reg  <= result_next;
        end
    end

    assign bus.done       = done_reg;
    assign bus.illegal_op = illegal_reg;
    assign bus.result     = result_reg;
    assign bus.busy       = (state_reg == BUSY_MUL) || launch;

endmodule

// File: tb/tb_tinyalu_core.sv
// Scoreboard bench for tinyalu_core: the driver pushes the expected response
// of each launched operation, a negedge monitor pops and checks it on done.
module tb_tinyalu_core;
    import tinyalu_ops_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] last_res = 16'h0000;

    typedef struct {
        logic [15:0] res;
        logic        ill;
        int          launch;
        int          lat;
    } exp_t;

    exp_t sb[$];

    tinyalu_core_if bus ();

    tinyalu_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural reference: plain arithmetic on the operands.
    function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        x = int'(a);
        y = int'(b);
        case (o)
            3'd1:    return 16'(x + y);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(x * y);
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("illegal_op", bus.illegal_op, e.ill);
                check("latency", cyc - e.launch, e.lat);
                $display("op done: result=%04h illegal=%0b latency=%0d", bus.result, bus.illegal_op, cyc - e.launch);
            end
        end else if (bus.illegal_op) begin
            check("illegal_without_done", 1, 0);
        end
    end

    // Issue one request, hold start 'hold' extra cycles after done, then drop it.
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input bit scramble);
        bit   seen;
        exp_t e;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = operation_t'(o);
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        check("busy_at_request", bus.busy, (o != 3'd0));
        @(posedge clk); #1;
        if (o == 3'd0) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(posedge clk); #1;
            check("noop_result_held", bus.result, last_res);
            $display("no_op ignored: result=%04h", bus.result);
            return;
        end
        e.res = model(o, a, b);
        e.ill = (o >= 3'd5);
        e.launch = cyc;
        e.lat = (o == 3'd4) ? 3 : 0;
        sb.push_back(e);
        last_res = e.res;
        if (scramble) begin
            bus.A  = 8'($urandom);
            bus.B  = 8'($urandom);
            bus.op = operation_t'(3'($urandom_range(1, 7)));
        end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (i == 0) check("busy_during_mul", bus.busy, 1);
        end
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
        check("busy_after_done", bus.busy, 0);
        check("done_single_pulse", bus.done, 0);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = NO_OP;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_done", bus.done, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_illegal", bus.illegal_op, 0);
        check("reset_result", bus.result, 0);
        reset_n = 1'b1;

        // Directed cases.
        do_op(3'd1, 8'hFF, 8'h01, 0, 1'b0);   // add carry -> 0100
        do_op(3'd4, 8'hFF, 8'hFF, 0, 1'b1);   // mul, operands scrambled at L+1
        do_op(3'd0, 8'h12, 8'h34, 0, 1'b0);   // no_op held two cycles
        do_op(3'd3, 8'hF0, 8'h3C, 0, 1'b0);   // xor -> 00CC
        do_op(3'd2, 8'hAA, 8'h0F, 5, 1'b0);   // and, start held 5 cycles
        do_op(3'd6, 8'h55, 8'h66, 0, 1'b0);   // reserved -> illegal, 0000

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = MUL_OP;
        bus.A     = 8'h10;
        bus.B     = 8'h10;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = NO_OP;
        @(negedge clk);
        check("abort_result", bus.result, 0);
        check("abort_done", bus.done, 0);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_result_after", bus.result, 0);
        $display("mul aborted by reset: result=%04h", bus.result);
        last_res = 16'h0000;
        do_op(3'd1, 8'h01, 8'h02, 0, 1'b0);   // add -> 0003

        // Randomized operations against the reference model.
        for (int n = 0; n < 30; n++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
